mat_vec_stream_io: RTL

Streaming front/back end for the matrix-vector multiply array. Accepts matrix and vector elements one per beat over a valid/ready input stream and assembles them into the flat `M`/`X` buses that drive the array. It then sequences the array's MAC clear and run, captures the `Mdata` results, and returns them one per beat over a valid/ready output stream. The block sits between a narrow host/DMA stream and the parallel compute array.

---
 rtl/mat_vec_stream_io.sv | 84 ++++++++
 1 files changed

// File: rtl/mat_vec_stream_io.sv
// mat_vec_stream_io: streams matrix/vector elements into the array's M/X buses, sequences MAC clear/run, and streams results back out
module mat_vec_stream_io #(
  parameter int Mdata = 4,
  parameter int Ndata = 4,
  parameter int Nbits = 8,
  parameter int Lat   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [Nbits-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [Mdata*Ndata*Nbits-1:0] M,
  output logic [Ndata*Nbits-1:0]     X,
  output logic                       mac_reset,
  input  logic [Mdata*2*Nbits-1:0]   res,
  output logic [2*Nbits-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);
  localparam int MN  = Mdata*Ndata;
  localparam int TOT = (Mdata+1)*Ndata;
  localparam int KW  = $clog2(TOT+1);
  localparam int CW  = $clog2(Lat+1);
  localparam int RW  = $clog2(Mdata+1);
  typedef enum logic [2:0] {LOAD, CLEAR, RUN, CAPTURE, SEND} state_t;
  state_t                     r_state;
  logic [KW-1:0]              r_k;
  logic [CW-1:0]              r_c;
  logic [RW-1:0]              r_r;
  logic [MN*Nbits-1:0]        r_m;
  logic [Ndata*Nbits-1:0]     r_x;
  logic [Mdata*2*Nbits-1:0]   r_sh;
  logic                       w_last_in;
  logic                       w_last_out;
  assign w_last_in  = r_k == KW'(TOT-1);
  assign w_last_out = r_r == RW'(Mdata-1);
  assign in_ready   = r_state == LOAD && !reset;
  assign out_valid  = r_state == SEND && !reset;
  assign busy       = r_state != LOAD && !reset;
  assign mac_reset  = reset || r_state == CLEAR;
  assign M          = r_m;
  assign X          = r_x;
  assign out_data   = r_sh[r_r*2*Nbits +: 2*Nbits];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_k     <= '0;
      r_c     <= '0;
      r_r     <= '0;
      r_m     <= '0;
      r_x     <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        LOAD: if (in_valid) begin
          if (r_k < KW'(MN)) r_m[r_k*Nbits +: Nbits] <= in_data;
          else r_x[(r_k-KW'(MN))*Nbits +: Nbits] <= in_data;
          r_k     <= w_last_in ? '0 : r_k + 1'b1;
          r_state <= w_last_in ? CLEAR : LOAD;
        end
        CLEAR: begin
          r_c     <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_c     <= r_c + 1'b1;
          r_state <= r_c == CW'(Lat-1) ? CAPTURE : RUN;
        end
        CAPTURE: begin
          r_sh    <= res;
          r_r     <= '0;
          r_state <= SEND;
        end
        SEND: if (out_ready) begin
          r_r     <= w_last_out ? '0 : r_r + 1'b1;
          r_state <= w_last_out ? LOAD : SEND;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule
